// File: rtl/pipe_ctrl_pkg.sv
// Shared encodings for the pipeline controller: FSM states, stall patterns,
// exception type codes and reset/zero constants.
package pipe_ctrl_pkg;

    typedef enum logic {
        ST_RUN   = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    localparam logic        RST_ENABLE = 1'b1;
    localparam logic [31:0] ZERO_WORD  = 32'h0000_0000;

    // Each stall pattern freezes the requesting stage and everything upstream of it.
    localparam logic [5:0] STALL_NONE = 6'b000000;
    localparam logic [5:0] STALL_ID   = 6'b000111;
    localparam logic [5:0] STALL_EX   = 6'b001111;
    localparam logic [5:0] STALL_MEM  = 6'b011111;

    localparam logic [31:0] EXC_NONE    = 32'h0000_0000;
    localparam logic [31:0] EXC_INT     = 32'h0000_0001;
    localparam logic [31:0] EXC_SYSCALL = 32'h0000_0008;
    localparam logic [31:0] EXC_INVALID = 32'h0000_000a;
    localparam logic [31:0] EXC_OV      = 32'h0000_000c;
    localparam logic [31:0] EXC_TRAP    = 32'h0000_000d;
    localparam logic [31:0] EXC_ERET    = 32'h0000_000e;

endpackage

// File: rtl/pipe_ctrl.sv
// Pipeline controller: stall arbitration, exception flush/redirect,
// memory-bus timeout detection and stall-cycle accounting.
module pipe_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter logic [31:0] HANDLER_PC     = 32'h0000_0020,
    parameter logic [31:0] GEN_HANDLER_PC = 32'h0000_0040,
    parameter logic [7:0]  MEM_TIMEOUT    = 8'd255
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stallreq_id,
    input  logic        stallreq_ex,
    input  logic        stallreq_mem,
    input  logic [31:0] excepttype,
    input  logic [31:0] cp0_epc,
    output logic [5:0]  stall,
    output logic        flush,
    output logic [31:0] new_pc,
    output logic        bus_timeout,
    output logic [31:0] stall_cycles
);

    state_t      state;
    state_t      next_state;
    logic [7:0]  mem_cnt;
    logic [7:0]  mem_cnt_inc;
    logic        mem_count_en;
    logic        take_exception;

    function automatic logic [31:0] map_new_pc(input logic [31:0] code,
                                               input logic [31:0] epc);
        logic [31:0] pc;
        case (code)
            EXC_INT:                                  pc = HANDLER_PC;
            EXC_SYSCALL, EXC_INVALID, EXC_OV, EXC_TRAP: pc = GEN_HANDLER_PC;
            EXC_ERET:                                 pc = epc;
            default:                                  pc = GEN_HANDLER_PC;
        endcase
        return pc;
    endfunction

    assign take_exception = (state == ST_RUN) && (excepttype != EXC_NONE);

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            state <= ST_RUN;
        end else begin
            state <= next_state;
        end
    end

    // A flush lasts exactly one cycle; exceptions seen during it are dropped.
    always_comb begin
        next_state = state;
        case (state)
            ST_RUN:   if (excepttype != EXC_NONE) next_state = ST_FLUSH;
            ST_FLUSH: next_state = ST_RUN;
            default:  next_state = ST_RUN;
        endcase
    end

    always_comb begin
        stall = STALL_NONE;
        if (rst != RST_ENABLE && state == ST_RUN) begin
            if (stallreq_mem)      stall = STALL_MEM;
            else if (stallreq_ex)  stall = STALL_EX;
            else if (stallreq_id)  stall = STALL_ID;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            flush  <= 1'b0;
            new_pc <= ZERO_WORD;
        end else if (take_exception) begin
            flush  <= 1'b1;
            new_pc <= map_new_pc(excepttype, cp0_epc);
        end else begin
            flush  <= 1'b0;
        end
    end

    // The bus-wait counter saturates at the limit so the timeout edge is unique.
    assign mem_count_en = (state == ST_RUN) && stallreq_mem;
    assign mem_cnt_inc  = (mem_cnt == MEM_TIMEOUT) ? mem_cnt : mem_cnt + 8'd1;

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            mem_cnt     <= 8'd0;
            bus_timeout <= 1'b0;
        end else if (!mem_count_en) begin
            mem_cnt <= 8'd0;
        end else begin
            mem_cnt <= mem_cnt_inc;
            if (mem_cnt_inc == MEM_TIMEOUT) bus_timeout <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst == RST_ENABLE) begin
            stall_cycles <= ZERO_WORD;
        end else if (stall != STALL_NONE && stall_cycles != 32'hFFFF_FFFF) begin
            stall_cycles <= stall_cycles + 32'd1;
        end
    end

endmodule
